// File: rtl/blk_9ec7b6_pkg.sv
// Shared types and constants for the input_mmap AXI4 read responder.
// The AR request struct is sized for the widest address any instance may use.
package input_loader_s_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int AR_ADDR_W = 64;
    localparam int AR_LEN_W  = 8;

    typedef enum logic {
        IDLE,
        BURST
    } rd_state_t;

    typedef struct packed {
        logic [AR_ADDR_W-1:0] addr;
        logic [AR_LEN_W-1:0]  len;
    } ar_req_t;

    function automatic int byte_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/blk_9ec7b6_ar_fifo.sv
// Register FIFO of pending AR requests with registered full_n / empty_n flags.
// full_n resets low so the AR channel stays closed for the reset cycle.
module input_loader_r1_ln_iembed_fp32_input_mmap_s_axi_ar_fifo
    import input_loader_s_axi_pkg::*;
#(
    parameter int AR_DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    clk_en,
    input  logic    push,
    input  ar_req_t push_data,
    output logic    full_n,
    input  logic    pop,
    output ar_req_t pop_data,
    output logic    empty_n
);

    localparam int PW = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
    localparam int CW = $clog2(AR_DEPTH + 1);

    ar_req_t         slots [AR_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nx;
    logic            do_push;
    logic            do_pop;

    assign do_push  = push & full_n;
    assign do_pop   = pop & empty_n;
    assign pop_data = slots[rd_ptr];

    always_comb begin
        count_nx = count;
        if (do_push && !do_pop) begin
            count_nx = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_nx = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_n  <= 1'b0;
            empty_n <= 1'b0;
        end else if (clk_en) begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(AR_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(AR_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            count   <= count_nx;
            full_n  <= (count_nx != CW'(AR_DEPTH));
            empty_n <= (count_nx != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/blk_9ec7b6.sv
// AXI4 read-channel responder: queues AR bursts, reads beats from an on-chip word
// memory (backdoor-loaded) and returns them through a 2-entry skid buffer.
module blk_9ec7b6
    import input_loader_s_axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 10,
    parameter int AR_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_rlast,
    output logic [1:0]            s_rresp,
    input  logic                  mem_we,
    input  logic [MEM_AW-1:0]     mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy
);

    localparam int SH    = byte_shift(DATA_WIDTH);
    localparam int WW    = AR_ADDR_W + 1;
    localparam int DEPTH = 2 ** MEM_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ar_req_t   push_req;
    ar_req_t   head;
    logic      fifo_full_n;
    logic      fifo_empty_n;
    logic      pop;
    logic [WW-1:0] head_word;

    rd_state_t     state;
    rd_state_t     state_nx;
    logic [WW-1:0] cur_word;
    logic [WW-1:0] word_nx;
    logic [7:0]    remain;
    logic [7:0]    remain_nx;

    logic          issue;
    logic          iss_last;
    logic          iss_oor;
    logic [WW-1:0] iss_word;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  last_p1;
    logic [1:0]            resp_p1;

    logic                  out_vld_p2;
    logic [DATA_WIDTH-1:0] out_data_p2;
    logic                  out_last_p2;
    logic [1:0]            out_resp_p2;
    logic                  skid_vld_p2;
    logic [DATA_WIDTH-1:0] skid_data_p2;
    logic                  skid_last_p2;
    logic [1:0]            skid_resp_p2;

    logic       rd_hs;
    logic       skid_load;
    logic [1:0] held;
    logic       can_issue;

    assign push_req.addr = AR_ADDR_W'(s_araddr);
    assign push_req.len  = s_arlen;

    input_loader_r1_ln_iembed_fp32_input_mmap_s_axi_ar_fifo #(
        .AR_DEPTH (AR_DEPTH)
    ) u_ar_fifo (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .push      (s_arvalid),
        .push_data (push_req),
        .full_n    (fifo_full_n),
        .pop       (pop),
        .pop_data  (head),
        .empty_n   (fifo_empty_n)
    );

    assign head_word = WW'(head.addr) >> SH;
    assign iss_oor   = |iss_word[WW-1:MEM_AW];

    // Beats already committed downstream, minus the one leaving this cycle,
    // must stay below 2 so the skid buffer can never overflow.
    assign rd_hs     = out_vld_p2 & s_rready;
    assign held      = 2'(out_vld_p2) + 2'(skid_vld_p2) + 2'(vld_p1);
    assign can_issue = (held < 2'd2) || ((held == 2'd2) && rd_hs);
    assign skid_load = vld_p1 & (skid_vld_p2 | (out_vld_p2 & ~s_rready));

    always_comb begin
        issue     = 1'b0;
        pop       = 1'b0;
        iss_word  = cur_word;
        iss_last  = (remain == '0);
        state_nx  = state;
        word_nx   = cur_word;
        remain_nx = remain;
        if (can_issue) begin
            if (state == IDLE) begin
                if (fifo_empty_n) begin
                    issue     = 1'b1;
                    pop       = 1'b1;
                    iss_word  = head_word;
                    iss_last  = (head.len == '0);
                    word_nx   = head_word + WW'(1);
                    remain_nx = head.len - 8'd1;
                    state_nx  = (head.len == '0) ? IDLE : BURST;
                end
            end else begin
                issue = 1'b1;
                if (iss_last) begin
                    // Reload straight from the queue so bursts run back to back.
                    if (fifo_empty_n) begin
                        pop       = 1'b1;
                        word_nx   = head_word;
                        remain_nx = head.len;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    word_nx   = cur_word + WW'(1);
                    remain_nx = remain - 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ---- p1: RAM read (old data wins against a same-cycle backdoor write) ----
    always_ff @(posedge clk) begin
        if (clk_en && issue) begin
            data_p1 <= iss_oor ? '0 : mem[iss_word[MEM_AW-1:0]];
            last_p1 <= iss_last;
            resp_p1 <= iss_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // ---- p2: output register plus skid entry ----
    always_ff @(posedge clk) begin
        if (clk_en && skid_load) begin
            skid_data_p2 <= data_p1;
            skid_last_p2 <= last_p1;
            skid_resp_p2 <= resp_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cur_word    <= '0;
            remain      <= '0;
            vld_p1      <= 1'b0;
            out_vld_p2  <= 1'b0;
            out_data_p2 <= '0;
            out_last_p2 <= 1'b0;
            out_resp_p2 <= RESP_OKAY;
            skid_vld_p2 <= 1'b0;
        end else if (clk_en) begin
            state    <= state_nx;
            cur_word <= word_nx;
            remain   <= remain_nx;
            vld_p1   <= issue;
            if (!out_vld_p2 || s_rready) begin
                if (skid_vld_p2) begin
                    out_vld_p2  <= 1'b1;
                    out_data_p2 <= skid_data_p2;
                    out_last_p2 <= skid_last_p2;
                    out_resp_p2 <= skid_resp_p2;
                    skid_vld_p2 <= vld_p1;
                end else begin
                    out_vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        out_data_p2 <= data_p1;
                        out_last_p2 <= last_p1;
                        out_resp_p2 <= resp_p1;
                    end
                end
            end else begin
                skid_vld_p2 <= skid_vld_p2 | vld_p1;
            end
        end
    end

    assign s_arready = fifo_full_n;
    assign s_rvalid  = out_vld_p2;
    assign s_rdata   = out_data_p2;
    assign s_rlast   = out_last_p2;
    assign s_rresp   = out_resp_p2;
    assign busy      = fifo_empty_n | (state == BURST) | vld_p1 | out_vld_p2 | skid_vld_p2;

endmodule
